// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction-fetch memory responder with programmable wait states and a side-band load port
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic        busy,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] TOP_ADDR  = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;
  localparam logic [7:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             ld_err_q, ld_err_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             req_ok;
  logic             ld_ok;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] ld_idx;

  function automatic logic in_window(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a <= TOP_ADDR) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign req_ok  = in_window(addr);
  assign req_idx = word_index(addr);
  assign ld_idx  = word_index(ld_addr);
  assign ld_ok   = rstn && ld_we && (state_q == S_IDLE) && in_window(ld_addr);

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    fault_d  = 1'b0;
    busy_d   = busy_q;
    ld_err_d = ld_we && !ld_ok;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          idx_d  = req_idx;
          busy_d = 1'b1;
          if (!req_ok) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            fault_d  = 1'b1;
            rdata_d  = '0;
          end else if (WAIT_CYCLES == 0) begin
            // Zero-wait read shares the edge with a possible load, so forward it
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rdata_d  = (ld_ok && (ld_idx == req_idx)) ? ld_data : mem[req_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign fault  = fault_q;
  assign busy   = busy_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed and randomized check of instr_mem_responder at several wait settings
module tb_instr_mem_responder;

  localparam int          NI   = 5;
  localparam logic [31:0] BASE = 32'h0100_0000;

  function automatic int ns_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      3:       return 5;
      default: return 255;
    endcase
  endfunction

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        req     = 1'b0;
  logic [31:0] addr    = '0;
  logic        ld_we   = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0]   rdata_w [NI];
  logic [NI-1:0] rvalid_w, fault_w, busy_w, ld_err_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instr_mem_responder #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(ns_of(g))
    ) u_dut (
      .clk    (clk),
      .rstn   (rstn),
      .req    (req),
      .addr   (addr),
      .rdata  (rdata_w[g]),
      .rvalid (rvalid_w[g]),
      .fault  (fault_w[g]),
      .busy   (busy_w[g]),
      .ld_we  (ld_we),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .ld_err (ld_err_w[g])
    );
  end

  int          n_cmp  = 0;
  int          n_bad  = 0;
  bit          cmp_on = 1'b0;
  int          cyc    = 0;
  int          free_k   [NI];
  int          resp_k   [NI];
  bit          pend_bad [NI];
  int          pend_idx [NI];
  logic [31:0] mm       [NI][1024];
  logic [31:0] e_rdata  [NI];
  bit          e_rvalid [NI];
  bit          e_fault  [NI];
  bit          e_busy   [NI];
  bit          e_lderr  [NI];
  logic [31:0] fill     [1024];

  function automatic bit good(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'hFFC) && (a[1:0] == 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 1023;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] odd [4];
    odd[0] = 32'h0000_0000;
    odd[1] = 32'hFFFF_FFFC;
    odd[2] = 32'h00FF_FFFC;
    odd[3] = 32'h0100_1000;
    case ($urandom % 8)
      0, 1, 2, 3, 4: return BASE + 4 * ($urandom % 1024);
      5:             return BASE + 4 * ($urandom % 1024) + 1 + ($urandom % 3);
      6:             return odd[$urandom % 4];
      default:       return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d (N=%0d) at %0t: got %h want %h", name, i, ns_of(i), $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      free_k[i]   = 0;
      resp_k[i]   = -1;
      e_rvalid[i] = 1'b0;
      e_fault[i]  = 1'b0;
      e_busy[i]   = 1'b0;
      e_lderr[i]  = 1'b0;
      e_rdata[i]  = '0;
    end
  endtask

  // Transaction-level timing: accepted at edge c, answered at c (fault) or c+N, free again two edges later
  task automatic model_step();
    bit idle;
    cyc++;
    if (!rstn) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        idle       = (cyc >= free_k[i]);
        e_lderr[i] = 1'b0;
        if (ld_we) begin
          if (idle && good(ld_addr)) mm[i][widx(ld_addr)] = ld_data;
          else e_lderr[i] = 1'b1;
        end
        if (idle && req) begin
          pend_bad[i] = !good(addr);
          pend_idx[i] = widx(addr);
          resp_k[i]   = pend_bad[i] ? cyc : cyc + ns_of(i);
          free_k[i]   = resp_k[i] + 2;
        end
        e_rvalid[i] = (cyc == resp_k[i]);
        e_fault[i]  = e_rvalid[i] && pend_bad[i];
        if (e_rvalid[i]) e_rdata[i] = pend_bad[i] ? 32'h0 : mm[i][pend_idx[i]];
        e_busy[i]   = (cyc <= resp_k[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic settle();
    repeat (262) tick();
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < NI; i++) begin
        chk("rvalid", i, 32'(rvalid_w[i]), 32'(e_rvalid[i]));
        chk("fault",  i, 32'(fault_w[i]),  32'(e_fault[i]));
        chk("busy",   i, 32'(busy_w[i]),   32'(e_busy[i]));
        chk("ld_err", i, 32'(ld_err_w[i]), 32'(e_lderr[i]));
        chk("rdata",  i, rdata_w[i],       e_rdata[i]);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int first [NI];
    int cnt   [NI];
    int nrv;

    model_reset();
    for (int w = 0; w < 1024; w++) fill[w] = $urandom;
    fill[0]    = 32'hDEAD_BEEF;
    fill[1023] = 32'h1234_5678;

    repeat (3) tick();
    cmp_on = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_rdata", i, rdata_w[i], 32'h0);
      chk("reset_busy",  i, 32'(busy_w[i]), 32'h0);
    end

    for (int w = 0; w < 1024; w++) begin
      ld_we = 1'b1; ld_addr = BASE + 4 * w; ld_data = fill[w];
      tick();
    end
    ld_we = 1'b0;
    tick();

    // Fetch word 0: N=0 answers right after acceptance, N=1 one edge later
    req = 1'b1; addr = 32'h0100_0000;
    tick(); req = 1'b0;
    chk("w0_n0_rvalid", 0, 32'(rvalid_w[0]), 32'h1);
    chk("w0_n0_rdata",  0, rdata_w[0], 32'hDEAD_BEEF);
    chk("w0_n1_busy",   1, 32'(busy_w[1]), 32'h1);
    chk("w0_n1_early",  1, 32'(rvalid_w[1]), 32'h0);
    tick();
    chk("w0_n1_rvalid", 1, 32'(rvalid_w[1]), 32'h1);
    chk("w0_n1_rdata",  1, rdata_w[1], 32'hDEAD_BEEF);
    chk("w0_n1_fault",  1, 32'(fault_w[1]), 32'h0);
    chk("w0_n1_busy2",  1, 32'(busy_w[1]), 32'h1);
    chk("w0_n0_idle",   0, 32'(busy_w[0]), 32'h0);
    tick();
    chk("w0_n1_done",   1, 32'(busy_w[1] | rvalid_w[1]), 32'h0);
    settle();

    req = 1'b1; addr = 32'h0100_0FFC;
    tick(); req = 1'b0;
    tick();
    chk("top_n1_rdata", 1, rdata_w[1], 32'h1234_5678);
    settle();

    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       addr = 32'h0100_1000;
        1:       addr = 32'h00FF_FFFC;
        default: addr = 32'h0100_0002;
      endcase
      req = 1'b1;
      tick(); req = 1'b0;
      chk("fault_rvalid", 4, 32'(rvalid_w[4]), 32'h1);
      chk("fault_flag",   4, 32'(fault_w[4]),  32'h1);
      chk("fault_rdata",  4, rdata_w[4], 32'h0);
      tick();
      chk("fault_clear",  4, 32'(rvalid_w[4] | fault_w[4] | busy_w[4]), 32'h0);
      tick();
    end

    // Latency sweep with an extra request while the N=255 instance is still busy
    req = 1'b1; addr = BASE + 12;
    tick();
    for (int i = 0; i < NI; i++) begin first[i] = -1; cnt[i] = 0; end
    for (int t = 0; t < 270; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (rvalid_w[i]) begin
          if (first[i] < 0) first[i] = t;
          cnt[i]++;
        end
      end
      req = (t == 100); addr = BASE + 8;
      tick();
    end
    req = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("latency", i, 32'(first[i]), 32'(ns_of(i)));
      chk("resp_count", i, 32'(cnt[i]), (i == 4) ? 32'd1 : 32'd2);
    end
    settle();

    req = 1'b1; addr = BASE;
    tick(); req = 1'b0;
    ld_we = 1'b1; ld_addr = BASE + 32; ld_data = 32'h1111_2222;
    tick(); ld_we = 1'b0;
    for (int i = 0; i < NI; i++) chk("ld_busy_err", i, 32'(ld_err_w[i]), 32'h1);
    tick();
    for (int i = 0; i < NI; i++) chk("ld_err_pulse", i, 32'(ld_err_w[i]), 32'h0);
    settle();
    req = 1'b1; addr = BASE + 32;
    tick(); req = 1'b0;
    chk("ld_busy_kept", 0, rdata_w[0], fill[8]);
    settle();

    ld_we = 1'b1; ld_addr = 32'h0200_0000; ld_data = 32'h5555_AAAA;
    tick(); ld_we = 1'b0;
    for (int i = 0; i < NI; i++) chk("ld_bad_err", i, 32'(ld_err_w[i]), 32'h1);
    tick();

    req = 1'b1; addr = BASE + 16; ld_we = 1'b1; ld_addr = BASE + 16; ld_data = 32'hA5A5_A5A5;
    tick(); req = 1'b0; ld_we = 1'b0;
    chk("same_edge_n0", 0, rdata_w[0], 32'hA5A5_A5A5);
    chk("same_edge_err", 0, 32'(ld_err_w[0]), 32'h0);
    tick();
    chk("same_edge_n1", 1, rdata_w[1], 32'hA5A5_A5A5);
    settle();
    chk("same_edge_n255", 4, rdata_w[4], 32'hA5A5_A5A5);

    // Asynchronous reset while N=5 is waiting
    req = 1'b1; addr = BASE + 4;
    tick(); req = 1'b0;
    tick(); tick();
    chk("pre_reset_busy", 3, 32'(busy_w[3]), 32'h1);
    #1 rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",   3, 32'(busy_w[3]), 32'h0);
    chk("rst_rvalid", 3, 32'(rvalid_w[3]), 32'h0);
    chk("rst_rdata",  3, rdata_w[3], 32'h0);
    chk("rst_busy",   4, 32'(busy_w[4]), 32'h0);
    tick(); tick();
    rstn = 1'b1;
    nrv = 0;
    repeat (300) begin
      tick();
      for (int i = 0; i < NI; i++) nrv += int'(rvalid_w[i]);
    end
    chk("no_resp_after_reset", 0, 32'(nrv), 32'h0);
    req = 1'b1; addr = BASE;
    tick(); req = 1'b0;
    chk("mem_kept", 0, rdata_w[0], 32'hDEAD_BEEF);
    settle();

    // req held high: N=0 serves every other edge
    for (int t = 0; t < 20; t++) begin
      req = 1'b1; addr = BASE + 4 * (100 + t);
      tick();
      if (t % 2 == 0) begin
        chk("b2b_rvalid", 0, 32'(rvalid_w[0]), 32'h1);
        chk("b2b_rdata",  0, rdata_w[0], fill[100 + t]);
      end else begin
        chk("b2b_bubble", 0, 32'(rvalid_w[0]), 32'h0);
      end
    end
    req = 1'b0;
    settle();

    for (int n = 0; n < 2500; n++) begin
      req     = (($urandom % 3) == 0);
      addr    = rand_addr();
      ld_we   = (($urandom % 4) == 0);
      ld_addr = rand_addr();
      ld_data = $urandom;
      tick();
    end
    req = 1'b0; ld_we = 1'b0;
    settle();

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
